// File: rtl/ex_mem_reg_pkg.sv
// Shared widths, branch condition codes and flag bit positions for the EX->MEM register.
package ex_mem_reg_pkg;

  localparam int DSIZE = 16;
  localparam int AW    = 4;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    BR_NEVER = 3'b000,
    BR_EQ    = 3'b001,
    BR_NE    = 3'b010,
    BR_LT    = 3'b011,
    BR_GT    = 3'b100,
    BR_GE    = 3'b101,
    BR_OV    = 3'b110,
    BR_ALWAYS = 3'b111
  } br_cond_e;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX-side inputs and MEM-side outputs of the EX->MEM register; ovf_trap exists only with OVF_TRAP_EN.
interface ex_mem_reg_if;
  import ex_mem_reg_pkg::*;

  logic             ex_valid;
  logic [DSIZE-1:0] ex_alu_out;
  logic [2:0]       ex_flag;
  logic             ex_flag_we;
  logic [DSIZE-1:0] ex_store_data;
  logic [AW-1:0]    ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             ex_br;
  logic [2:0]       ex_br_cond;

  logic             mem_valid;
  logic [DSIZE-1:0] mem_alu_out;
  logic [DSIZE-1:0] mem_store_data;
  logic [AW-1:0]    mem_rd;
  logic             mem_reg_write;
  logic             mem_mem_read;
  logic             mem_mem_write;
  logic [2:0]       flag_q;
  logic             br_taken;
`ifdef OVF_TRAP_EN
  logic             ovf_trap;
`endif

  modport master (
    output ex_valid, ex_alu_out, ex_flag, ex_flag_we, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_br, ex_br_cond,
    input  mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, flag_q, br_taken
`ifdef OVF_TRAP_EN
    , input ovf_trap
`endif
  );

  modport slave (
    input  ex_valid, ex_alu_out, ex_flag, ex_flag_we, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_br, ex_br_cond,
    output mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
           mem_mem_read, mem_mem_write, flag_q, br_taken
`ifdef OVF_TRAP_EN
    , output ovf_trap
`endif
  );

endinterface

// File: rtl/ex_mem_reg_br_cond_eval.sv
// Branch condition evaluator: condition code x {Z,V,N} flags -> taken. Purely combinational.
module br_cond_eval
  import ex_mem_reg_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (br_cond_e'(cond))
      BR_NEVER:  taken = 1'b0;
      BR_EQ:     taken = z;
      BR_NE:     taken = ~z;
      BR_LT:     taken = n;
      BR_GT:     taken = ~z & ~n & ~v;
      BR_GE:     taken = ~n;
      BR_OV:     taken = v;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register plus {Z,V,N} flag register and branch resolve; 1-cycle latency, stall freezes all state.
// Optional OVF_TRAP_EN: overflowing flag-setting ops suppress writeback and pulse ovf_trap.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input logic         clk,
  input logic         rst,
  input logic         stall,
  input logic         flush,
  ex_mem_reg_if.slave bus
);

  logic             valid_q;
  logic [DSIZE-1:0] alu_q;
  logic [DSIZE-1:0] sd_q;
  logic [AW-1:0]    rd_q;
  logic             rw_q;
  logic             mr_q;
  logic             mw_q;
  logic [2:0]       flag_r;
  logic             cond_hit;
  logic             ovf;

`ifdef OVF_TRAP_EN
  logic trap_q;
  assign ovf = bus.ex_valid & bus.ex_flag_we & bus.ex_flag[FLAG_V];
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      sd_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      flag_r  <= 3'b000;
`ifdef OVF_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else if (!stall) begin
      if (flush) begin
        // Bubble: controls cleared, data fields left as they were.
        valid_q <= 1'b0;
        rw_q    <= 1'b0;
        mr_q    <= 1'b0;
        mw_q    <= 1'b0;
`ifdef OVF_TRAP_EN
        trap_q  <= 1'b0;
`endif
      end else begin
        valid_q <= bus.ex_valid;
        alu_q   <= bus.ex_alu_out;
        sd_q    <= bus.ex_store_data;
        rd_q    <= bus.ex_rd;
        rw_q    <= bus.ex_valid & bus.ex_reg_write & ~ovf;
        mr_q    <= bus.ex_valid & bus.ex_mem_read;
        mw_q    <= bus.ex_valid & bus.ex_mem_write;
        if (bus.ex_valid && bus.ex_flag_we)
          flag_r <= bus.ex_flag;
`ifdef OVF_TRAP_EN
        trap_q  <= ovf;
`endif
      end
    end
  end

  br_cond_eval u_br_cond_eval (
    .cond  (bus.ex_br_cond),
    .flags (flag_r),
    .taken (cond_hit)
  );

  // Not gated by stall: IF is responsible for honouring the stall itself.
  assign bus.br_taken = ~rst & bus.ex_valid & bus.ex_br & ~flush & cond_hit;

  assign bus.mem_valid      = valid_q;
  assign bus.mem_alu_out    = alu_q;
  assign bus.mem_store_data = sd_q;
  assign bus.mem_rd         = rd_q;
  assign bus.mem_reg_write  = rw_q;
  assign bus.mem_mem_read   = mr_q;
  assign bus.mem_mem_write  = mw_q;
  assign bus.flag_q         = flag_r;
`ifdef OVF_TRAP_EN
  assign bus.ovf_trap       = trap_q;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed scenarios then random traffic against a reference model.
module tb_ex_mem_reg;

  logic clk = 1'b0;
  logic rst, stall, flush;
  always #5 clk = ~clk;

  ex_mem_reg_if bus ();

  ex_mem_reg dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] alu;
    logic [2:0]  flag;
    logic        we;
    logic [15:0] sd;
    logic [3:0]  rd;
    logic        rw, mr, mw, br;
    logic [2:0]  cond;
  } ex_t;

  typedef struct packed {
    logic        v;
    logic [15:0] alu, sd;
    logic [3:0]  rd;
    logic        rw, mr, mw;
    logic [2:0]  flag;
    logic        trap;
  } st_t;

  st_t m;
  st_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
    logic z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !(z || n || v);
      3'd5: return !n;
      3'd6: return v;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ex_t mk(input logic v, input logic [15:0] alu, input logic [2:0] flag,
                             input logic we, input logic [3:0] rd, input logic rw,
                             input logic br, input logic [2:0] cond);
    ex_t e;
    e = '0;
    e.v = v; e.alu = alu; e.flag = flag; e.we = we; e.rd = rd; e.rw = rw;
    e.br = br; e.cond = cond; e.sd = 16'hA5A5;
    return e;
  endfunction

  task automatic cyc(input ex_t s, input logic r, input logic st, input logic fl);
    st_t nx, got;
    logic ovf;
    rst = r; stall = st; flush = fl;
    bus.ex_valid      = s.v;
    bus.ex_alu_out    = s.alu;
    bus.ex_flag       = s.flag;
    bus.ex_flag_we    = s.we;
    bus.ex_store_data = s.sd;
    bus.ex_rd         = s.rd;
    bus.ex_reg_write  = s.rw;
    bus.ex_mem_read   = s.mr;
    bus.ex_mem_write  = s.mw;
    bus.ex_br         = s.br;
    bus.ex_br_cond    = s.cond;
    #1;
    check("br_taken", bus.br_taken, !r && s.v && s.br && !fl && cond_ok(s.cond, m.flag));
`ifdef OVF_TRAP_EN
    ovf = s.v & s.we & s.flag[1];
`else
    ovf = 1'b0;
`endif
    nx = m;
    if (r) nx = '0;
    else if (st) nx = m;
    else if (fl) begin
      nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0; nx.trap = 0;
    end else begin
      nx.v = s.v; nx.alu = s.alu; nx.sd = s.sd; nx.rd = s.rd;
      nx.rw = s.v && s.rw && !ovf;
      nx.mr = s.v && s.mr;
      nx.mw = s.v && s.mw;
      if (s.v && s.we) nx.flag = s.flag;
      nx.trap = ovf;
    end
    exp_q.push_back(nx);
    m = nx;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      check("mem_valid", bus.mem_valid, got.v);
      check("mem_alu_out", bus.mem_alu_out, got.alu);
      check("mem_store_data", bus.mem_store_data, got.sd);
      check("mem_rd", bus.mem_rd, got.rd);
      check("mem_reg_write", bus.mem_reg_write, got.rw);
      check("mem_mem_read", bus.mem_mem_read, got.mr);
      check("mem_mem_write", bus.mem_mem_write, got.mw);
      check("flag_q", bus.flag_q, got.flag);
`ifdef OVF_TRAP_EN
      check("ovf_trap", bus.ovf_trap, got.trap);
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_t ones, e;
    logic [2:0] fsel [4];
    fsel[0] = 3'b000; fsel[1] = 3'b001; fsel[2] = 3'b010; fsel[3] = 3'b100;
    m = '0;
    ones = '1;

    // Reset with every EX input high.
    cyc(ones, 1, 0, 0);
    cyc(ones, 1, 0, 0);

    // Plain pipe transfer.
    cyc(mk(1, 16'h1234, 3'b000, 0, 4'd5, 1, 0, 3'd0), 0, 0, 0);
    check("pipe_alu_direct", bus.mem_alu_out, 16'h1234);

    // ADD sets Z, SLL leaves flags, then BEQ / BNE resolve against Z.
    cyc(mk(1, 16'h0000, 3'b100, 1, 4'd1, 1, 0, 3'd0), 0, 0, 0);
    cyc(mk(1, 16'h0002, 3'b001, 0, 4'd2, 1, 0, 3'd0), 0, 0, 0);
    check("flag_after_sll", bus.flag_q, 3'b100);
    cyc(mk(1, 16'h0000, 3'b000, 0, 4'd0, 0, 1, 3'd1), 0, 0, 0);
    cyc(mk(1, 16'h0000, 3'b000, 0, 4'd0, 0, 1, 3'd2), 0, 0, 0);

    // Store and load controls.
    e = mk(1, 16'h0040, 3'b000, 0, 4'd0, 0, 0, 3'd0); e.mw = 1; e.sd = 16'hBEEF;
    cyc(e, 0, 0, 0);
    e = mk(1, 16'h0044, 3'b000, 0, 4'd7, 1, 0, 3'd0); e.mr = 1;
    cyc(e, 0, 0, 0);

    // Stall together with flush holds everything; then flush alone bubbles.
    cyc(mk(1, 16'h5555, 3'b010, 1, 4'd9, 1, 1, 3'd7), 0, 1, 1);
    cyc(mk(1, 16'h6666, 3'b001, 1, 4'd3, 1, 0, 3'd0), 0, 0, 1);

    // Flushed SUB with V must not reach the flags; BOV then not taken.
    cyc(mk(1, 16'h8000, 3'b010, 1, 4'd4, 1, 0, 3'd0), 0, 0, 1);
    cyc(mk(1, 16'h0000, 3'b000, 0, 4'd0, 0, 1, 3'd6), 0, 0, 0);

    // Invalid slot with flag_we set does not update flags or controls.
    cyc(mk(0, 16'h0101, 3'b001, 1, 4'd6, 1, 0, 3'd0), 0, 0, 0);

    // Branch under stall still resolves; walk all conditions over each flag pattern.
    for (int f = 0; f < 4; f++) begin
      cyc(mk(1, 16'h0100, fsel[f], 1, 4'd8, 1, 0, 3'd0), 0, 0, 0);
      for (int c = 0; c < 8; c++)
        cyc(mk(1, 16'h0000, 3'b000, 0, 4'd0, 0, 1, 3'(c)), 0, (c % 3) == 0, 0);
    end

`ifdef OVF_TRAP_EN
    // 0x7FFF + 0x0001 overflows: writeback suppressed, trap pulses once.
    cyc(mk(1, 16'h8000, 3'b010, 1, 4'd3, 1, 0, 3'd0), 0, 0, 0);
    check("trap_pulse", bus.ovf_trap, 1);
    cyc(mk(1, 16'h0001, 3'b000, 0, 4'd3, 1, 0, 3'd0), 0, 0, 0);
    check("trap_clear", bus.ovf_trap, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      e.v    = $urandom_range(0, 3) != 0;
      e.alu  = 16'($urandom);
      e.flag = fsel[$urandom_range(0, 3)];
      e.we   = $urandom_range(0, 1);
      e.sd   = 16'($urandom);
      e.rd   = 4'($urandom);
      e.rw   = $urandom_range(0, 1);
      e.mr   = $urandom_range(0, 1);
      e.mw   = $urandom_range(0, 1);
      e.br   = $urandom_range(0, 1);
      e.cond = 3'($urandom);
      cyc(e, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
